mem_dp_strb: RTL
================

// Module: mem_dp_strb
// PURPOSE
//  Next-generation on-chip word memory for the DNASoC data path. It has one read
//  channel and one write channel, each with a valid/ready handshake, plus per-byte
//  write strobes. Out-of-range accesses are flagged. A 2-entry response buffer absorbs
//  read back-pressure. It sits between the core/bus adapter and local RAM.
// PARAMETERS
//  MEM_SIZE    4096  capacity in bytes; power of two, >= DATA_WIDTH/8
//  ADDR_WIDTH  32    byte-address width
//  DATA_WIDTH  32    word width; one of 32 or 64
//  (derived) STRB_W = DATA_WIDTH/8; LSB = log2(STRB_W); DEPTH = MEM_SIZE/STRB_W
// PORTS
//  clk           in   1           clock, all logic on rising edge
//  rst_n         in   1           synchronous active-low reset
//  rd_req_valid  in   1           read request valid
//  rd_req_ready  out  1           read request accepted when valid&&ready
//  rd_req_addr   in   ADDR_WIDTH  read byte address
//  rd_rsp_valid  out  1           read response valid
//  rd_rsp_ready  in   1           consumer accepts response
//  rd_rsp_data   out  DATA_WIDTH  read data
//  rd_rsp_err    out  1           1 = address out of range, data forced 0
//  wr_req_valid  in   1           write request valid
//  wr_req_ready  out  1           write request accepted when valid&&ready
//  wr_req_addr   in   ADDR_WIDTH  write byte address
//  wr_req_data   in   DATA_WIDTH  write data
//  wr_req_strb   in   STRB_W      byte enables; bit i writes data[8i+7:8i]
//  wr_ack        out  1           1-cycle pulse, one cycle after write accept
//  wr_err        out  1           valid with wr_ack; 1 = write dropped (out of range)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_err=0, wr_ack=0,
//    wr_err=0, buffer and in-flight count cleared. Memory contents are NOT cleared.
//    Reset mid-transaction discards in-flight reads and pending responses.
//  - Word index = addr[LSB +: log2(DEPTH)]. addr[LSB-1:0] is ignored (no misalign
//    error). Range check: addr >= MEM_SIZE -> error.
//  - Little-endian byte lanes: strobe bit 0 selects bits [7:0].
//  - Read pipeline: the array is read in the accept cycle N. The word enters the
//    response buffer at N+1, and rd_rsp_valid=1 from N+1 when the buffer was empty.
//    Minimum latency is 1 cycle. Responses are delivered strictly in request order.
//  - Credit count cnt = in-flight (0/1) + buffer entries (0..2).
//    rd_req_ready = (cnt < 2). It is registered-state only, with no combinational
//    path from rd_rsp_ready. Throughput is 1 read/cycle while rd_rsp_ready=1.
//  - rd_rsp_* hold stable while rd_rsp_valid && !rd_rsp_ready. A pop and a push in
//    the same cycle keep cnt balanced.
//  - Out-of-range read: the array is not read, and the response is data=0, err=1
//    with normal latency and ordering.
//  - wr_req_ready = rst_n-registered 1: it is 0 during reset and 1 thereafter, so
//    every write is accepted. On accept, bytes with strb=1 are written at the edge.
//    strb=0 gives a legal no-op, with wr_ack=1 and wr_err=0. Out of range: no array
//    update, wr_ack=1, wr_err=1.
//  - Same-cycle read and write to the same word (no macro): the read returns the
//    OLD word (read-before-write).
//  - Simultaneous read and write to different words proceed independently.
// CONFIGURATION
//  RDW_FWD_EN defined: on a same-cycle read+write to the same in-range word, the
//   read response returns merged data: new bytes where strb=1, old bytes elsewhere.
//   Adds one DATA_WIDTH bypass mux and no latency.
//  RDW_FWD_EN undefined: read-before-write as in BEHAVIOUR.
//  Writes accepted in earlier cycles are always visible to later reads in both
//  builds.
// TESTING
//  1 Write 0x0000_0010 data 0xDEADBEEF strb 4'hF, then read 0x10 -> wr_ack=1,
//    wr_err=0; rd_rsp_data 0xDEADBEEF, err=0, 1 cycle after accept.
//  2 Write 0x10 data 0x11223344 strb 4'b0101 over 0xDEADBEEF, then read ->
//    0xDE22BE44.
//  3 Hold rd_rsp_ready=0 and issue 4 back-to-back reads -> 2 accepted, then
//    rd_req_ready=0 and data stable. Release -> remaining reads complete in order,
//    with no loss or duplication.
//  4 Read 0x1000, and write 0x1000 with MEM_SIZE=4096 -> read data=0, err=1;
//    wr_err=1. Word 0 is unchanged (no wrap-around alias).
//  5 Same-cycle write 0x20 := 0xA5A5A5A5 (old 0x0) and read 0x20 -> 0x00000000
//    without RDW_FWD_EN; 0xA5A5A5A5 with it.
//  6 Assert rst_n=0 with 2 responses pending -> next cycle rd_rsp_valid=0,
//    rd_req_ready=0. After release, memory still holds the prior writes.

Source files
------------

// File: rtl/mem_dp_strb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_dp_strb : word memory with valid/ready read and write channels,        |
// |   per-byte write strobes, range checking and a 2-entry read response FIFO. |
// | Optional macro RDW_FWD_EN: same-cycle write-to-read forwarding.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_dp_strb #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
  output logic                    rd_rsp_valid,
  input  logic                    rd_rsp_ready,
  output logic [DATA_WIDTH-1:0]   rd_rsp_data,
  output logic                    rd_rsp_err,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
  input  logic [DATA_WIDTH-1:0]   wr_req_data,
  input  logic [DATA_WIDTH/8-1:0] wr_req_strb,
  output logic                    wr_ack,
  output logic                    wr_err
);

  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_LSB    = $clog2(c_STRB_W);
  localparam int c_DEPTH  = MEM_SIZE / c_STRB_W;
  localparam int c_IDX_W  = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_err;
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;
  logic                  r_wr_ack;
  logic                  r_wr_err;

  logic                  w_rd_oor;
  logic                  w_wr_oor;
  logic [c_IDX_W-1:0]    w_rd_idx;
  logic [c_IDX_W-1:0]    w_wr_idx;
  logic                  w_rd_push;
  logic                  w_rd_pop;
  logic                  w_wr_acc;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Range check is done on the full address so high addresses never alias.
  assign w_rd_oor  = ({1'b0, rd_req_addr} >= c_LIMIT);
  assign w_wr_oor  = ({1'b0, wr_req_addr} >= c_LIMIT);
  assign w_rd_idx  = rd_req_addr[c_LSB +: c_IDX_W];
  assign w_wr_idx  = wr_req_addr[c_LSB +: c_IDX_W];

  assign w_rd_push = rd_req_valid && rd_req_ready;
  assign w_rd_pop  = rd_rsp_valid && rd_rsp_ready;
  assign w_wr_acc  = wr_req_valid && wr_req_ready;
  assign w_wr_en   = w_wr_acc && !w_wr_oor;

  always_comb begin
    w_rd_word = '0;
    if (!w_rd_oor) begin
      w_rd_word = r_mem[w_rd_idx];
`ifdef RDW_FWD_EN
      if (w_wr_en && (w_wr_idx == w_rd_idx)) begin
        for (int b = 0; b < c_STRB_W; b++) begin
          if (wr_req_strb[b]) begin
            w_rd_word[8*b +: 8] = wr_req_data[8*b +: 8];
          end
        end
      end
`endif
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < c_STRB_W; b++) begin
        if (wr_req_strb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= wr_req_data[8*b +: 8];
        end
      end
    end
  end

  // Response FIFO: the array word lands here at the accept edge, so the
  // credit count only needs to track buffer occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= 2'd0;
      r_buf_err <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
      end
    end else begin
      if (w_rd_push) begin
        r_buf_data[r_wp] <= w_rd_word;
        r_buf_err[r_wp]  <= w_rd_oor;
        r_wp             <= ~r_wp;
      end
      if (w_rd_pop) begin
        r_rp <= ~r_rp;
      end
      case ({w_rd_push, w_rd_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_wr_ack <= w_wr_acc;
      r_wr_err <= w_wr_acc && w_wr_oor;
    end
  end

  assign rd_req_ready = r_run && (r_cnt != 2'd2);
  assign rd_rsp_valid = (r_cnt != 2'd0);
  assign rd_rsp_data  = r_buf_data[r_rp];
  assign rd_rsp_err   = r_buf_err[r_rp];
  assign wr_req_ready = r_run;
  assign wr_ack       = r_wr_ack;
  assign wr_err       = r_wr_err;

endmodule
`default_nettype wire
